mod_add_prefix_pipe: RTL and testbench
======================================

MOD_ADD_PREFIX_PIPE -- requirements
Module: mod_add_prefix_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 7, operand width n; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  input vector set valid.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have ports g_i, p_i, h_i  input  WIDTH  generate/propagate/half-sum of A+B, from the hashed-cell row.
REQ-007 SHALL have ports gq_i, pq_i, hq_i  input  WIDTH  generate/propagate/half-sum of A+B+K, from the enveloped-cell row.
REQ-008 SHALL have port bq_msb_i  input  1  carry-save bit b'[n-1] (weight 2^n) of A+B+K.
REQ-009 SHALL have port out_valid  output  1  sum_o valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts sum_o.
REQ-011 SHALL have port sum_o  output  WIDTH  (A+B) mod M, M = 2^n-K.
REQ-012 SHALL have port wrap_o  output  1  1 when the A+B+K path was selected.

Function
REQ-013 SHALL compute carries c[i] = G[i:0] and c'[i] = G'[i:0] with a Sklansky parallel-prefix network of S = ceil(log2 WIDTH) levels, using (g,p)o(g',p') = (g | p&g', p&p').
REQ-014 SHALL form s[i] = h[i]^c[i-1] and s'[i] = hq[i]^c'[i-1], with c[-1] = c'[-1] = 0.
REQ-015 SHALL set sel = c'[n-1] | bq_msb, sum_o = sel ? s' : s, and wrap_o = sel.
REQ-016 SHALL capture inputs in an input register, which is pipeline stage 0, and register sum_o/wrap_o in an output stage; latency is defined in REQ-026.
REQ-017 SHALL advance the whole pipeline when adv = out_ready | ~out_valid, drive in_ready = adv combinationally, and accept a transfer only when in_valid & in_ready.
REQ-018 SHALL carry a valid bit per stage, so bubbles propagate and are never presented as out_valid.
REQ-019 SHALL hold sum_o, wrap_o, out_valid and all stage contents unchanged while out_valid & ~out_ready.
REQ-020 SHALL, on a simultaneous accept and emit, move all stages by one in the same cycle with no lost or duplicated beat.
REQ-021 SHALL sustain throughput of 1 result per cycle when out_ready is held at 1.
REQ-022 SHALL produce correct results for any A, B < M; behaviour for A or B >= M is don't-care but deterministic.

Reset
REQ-023 SHALL, on rst assertion (including mid-operation), clear all stage valid bits, out_valid, sum_o and wrap_o to 0 immediately, discarding in-flight beats.
REQ-024 SHALL drive in_ready = 1 during and after reset, since out_valid = 0.
REQ-025 SHALL not require reset on data registers other than sum_o and wrap_o.

Configuration
REQ-026 SHALL support macro MOD_ADD_PREFIX_PIPE_EN: when defined, each prefix level is registered and latency = S+2 (5 for WIDTH=7); when undefined, the prefix network is combinational between the input and output registers and latency = 2; handshake rules are identical in both builds.

Structure
REQ-027 SHALL place in shared package mod_add_pkg: the default width constant, the prefix-level-count function ceil(log2), and a packed (g,p) pair typedef.
REQ-028 SHALL implement one prefix level in a single sub-module, mod_add_prefix_level (parameters WIDTH and LEVEL), instantiated S times for each of the two carry chains.

Verification (WIDTH=7, K=20, M=108; vectors produced by the upstream cell rows from A, B, K)
REQ-029 SHALL check A=69, B=45 -> sum_o=6, wrap_o=1, appearing exactly 5 cycles after accept (2 without the macro).
REQ-030 SHALL check A=10, B=20 -> sum_o=30, wrap_o=0; and A=107, B=0 -> sum_o=107, wrap_o=0.
REQ-031 SHALL check the boundary A=107, B=1 -> sum_o=0, wrap_o=1; and A=107, B=107 -> sum_o=106, wrap_o=1.
REQ-032 SHALL check back-to-back inputs 69+45, 10+20, 107+1 with out_ready low for 3 cycles after the first out_valid -> first result held stable, in_ready=0 while stalled, then outputs 6, 30, 0 in order with none lost.
REQ-033 SHALL check rst pulsed with 3 beats in flight -> out_valid=0 and sum_o=0 asynchronously; no stale beat emitted after release; the next input 10+20 -> 30 at nominal latency.
REQ-034 SHALL check 1000 random legal (A, B) pairs with random in_valid and out_ready against the reference (A+B) mod 108, with order preserved.

Source files
------------

// File: rtl/mod_add_pkg.sv
// Shared types and helpers for the modulo-(2^n - K) prefix adder pipeline.
package mod_add_pkg;

  localparam int DEFAULT_WIDTH = 7;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Number of Sklansky levels: ceil(log2(w)).
  function automatic int prefix_levels(input int w);
    int s;
    s = 0;
    while ((1 << s) < w) s = s + 1;
    return s;
  endfunction

  // Prefix operator: hi covers the more significant span, lo the adjacent lower span.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/mod_add_prefix_level.sv
// One combinational Sklansky prefix level; bits with LEVEL-bit set absorb the top of the lower block.
module mod_add_prefix_level
  import mod_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LEVEL = 0
) (
  input  gp_t [WIDTH-1:0] gp_i,
  output gp_t [WIDTH-1:0] gp_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (((i >> LEVEL) % 2) == 1) begin : g_comb
      localparam int J = ((i >> LEVEL) << LEVEL) - 1;
      assign gp_o[i] = gp_combine(gp_i[i], gp_i[J]);
    end else begin : g_pass
      assign gp_o[i] = gp_i[i];
    end
  end

endmodule

// File: rtl/mod_add_prefix_pipe.sv
// Pipelined modulo adder final stage: two Sklansky carry chains choose between A+B and A+B+K.
// Define MOD_ADD_PREFIX_PIPE_EN to register every prefix level (latency S+2 instead of 2).
module mod_add_prefix_pipe
  import mod_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] h_i,
  input  logic [WIDTH-1:0] gq_i,
  input  logic [WIDTH-1:0] pq_i,
  input  logic [WIDTH-1:0] hq_i,
  input  logic             bq_msb_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_o,
  output logic             wrap_o
);

  localparam int S = prefix_levels(WIDTH);

  // Handshake: the whole pipeline moves together when adv = out_ready | ~out_valid.
  // in_ready mirrors adv; a beat transfers in when in_valid & in_ready and out when
  // out_valid & out_ready. While out_valid & ~out_ready every stage holds.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  logic             v0;
  logic [WIDTH-1:0] g0, p0, h0, gq0, pq0, hq0;
  logic             bqm0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v0 <= 1'b0;
    else if (adv) v0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      g0   <= g_i;
      p0   <= p_i;
      h0   <= h_i;
      gq0  <= gq_i;
      pq0  <= pq_i;
      hq0  <= hq_i;
      bqm0 <= bq_msb_i;
    end
  end

  for (genvar l = 0; l < S; l++) begin : g_lvl
    gp_t [WIDTH-1:0]  ab_in, abq_in, ab_nx, abq_nx, ab_out, abq_out;
    logic [WIDTH-1:0] h_in, hq_in, h_out, hq_out;
    logic             bqm_in, bqm_out, v_in, v_out;

    if (l == 0) begin : g_src
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign ab_in[i].g  = g0[i];
        assign ab_in[i].p  = p0[i];
        assign abq_in[i].g = gq0[i];
        assign abq_in[i].p = pq0[i];
      end
      assign h_in   = h0;
      assign hq_in  = hq0;
      assign bqm_in = bqm0;
      assign v_in   = v0;
    end else begin : g_chain
      assign ab_in  = g_lvl[l-1].ab_out;
      assign abq_in = g_lvl[l-1].abq_out;
      assign h_in   = g_lvl[l-1].h_out;
      assign hq_in  = g_lvl[l-1].hq_out;
      assign bqm_in = g_lvl[l-1].bqm_out;
      assign v_in   = g_lvl[l-1].v_out;
    end

    mod_add_prefix_level #(.WIDTH(WIDTH), .LEVEL(l)) u_ab (
      .gp_i (ab_in),
      .gp_o (ab_nx)
    );

    mod_add_prefix_level #(.WIDTH(WIDTH), .LEVEL(l)) u_abq (
      .gp_i (abq_in),
      .gp_o (abq_nx)
    );

`ifdef MOD_ADD_PREFIX_PIPE_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) v_out <= 1'b0;
      else if (adv) v_out <= v_in;
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        ab_out  <= ab_nx;
        abq_out <= abq_nx;
        h_out   <= h_in;
        hq_out  <= hq_in;
        bqm_out <= bqm_in;
      end
    end
`else
    assign ab_out  = ab_nx;
    assign abq_out = abq_nx;
    assign h_out   = h_in;
    assign hq_out  = hq_in;
    assign bqm_out = bqm_in;
    assign v_out   = v_in;
`endif
  end

  gp_t [WIDTH-1:0]  ab_last, abq_last;
  logic [WIDTH-1:0] c_ab, c_abq, h_l, hq_l, s_ab, s_abq, unused_p;
  logic             bqm_l, v_l, sel;

  assign ab_last  = g_lvl[S-1].ab_out;
  assign abq_last = g_lvl[S-1].abq_out;
  assign h_l      = g_lvl[S-1].h_out;
  assign hq_l     = g_lvl[S-1].hq_out;
  assign bqm_l    = g_lvl[S-1].bqm_out;
  assign v_l      = g_lvl[S-1].v_out;

  // Group propagate at the final level carries no information for the sum.
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign c_ab[i]     = ab_last[i].g;
    assign c_abq[i]    = abq_last[i].g;
    assign unused_p[i] = ab_last[i].p ^ abq_last[i].p;
  end

  assign s_ab  = h_l  ^ {c_ab[WIDTH-2:0], 1'b0};
  assign s_abq = hq_l ^ {c_abq[WIDTH-2:0], 1'b0};
  // A+B+K reaching 2^n means A+B >= M, so the wrapped sum is the low n bits of A+B+K.
  assign sel   = c_abq[WIDTH-1] | bqm_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum_o     <= '0;
      wrap_o    <= 1'b0;
    end else if (adv) begin
      out_valid <= v_l;
      if (v_l) begin
        sum_o  <= sel ? s_abq : s_ab;
        wrap_o <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mod_add_prefix_pipe.sv
// Bench for mod_add_prefix_pipe at WIDTH=7, K=20 (M=108); upstream cell rows modelled from A, B, K.
module tb_mod_add_prefix_pipe;

  localparam int W = 7;
  localparam int K = 20;
  localparam int M = 108;
`ifdef MOD_ADD_PREFIX_PIPE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] g_i, p_i, h_i, gq_i, pq_i, hq_i, sum_o;
  logic         bq_msb_i, wrap_o;

  logic [W:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  int a_cur, b_cur;
  logic drv_done;

  mod_add_prefix_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g_i       (g_i),
    .p_i       (p_i),
    .h_i       (h_i),
    .gq_i      (gq_i),
    .pq_i      (pq_i),
    .hq_i      (hq_i),
    .bq_msb_i  (bq_msb_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_o     (sum_o),
    .wrap_o    (wrap_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_mod(input int a, input int b);
    int s;
    logic [W:0] r;
    s = a + b;
    if (s >= M) r = {1'b1, W'(s - M)};
    else        r = {1'b0, W'(s)};
    return r;
  endfunction

  // Hashed row: half adders on A,B. Enveloped row: carry-save A+B+K then half adders.
  task automatic set_vec(input int a, input int b);
    logic [W-1:0] av, bv, kv, x, y, ys;
    av = W'(a);
    bv = W'(b);
    kv = W'(K);
    g_i = av & bv;
    p_i = av ^ bv;
    h_i = av ^ bv;
    x  = av ^ bv ^ kv;
    y  = (av & bv) | (av & kv) | (bv & kv);
    ys = {y[W-2:0], 1'b0};
    gq_i = x & ys;
    pq_i = x ^ ys;
    hq_i = x ^ ys;
    bq_msb_i = y[W-1];
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: got sum=%0d wrap=%0d, expected no output", sum_o, wrap_o);
        end else begin
          e = exp_q.pop_front();
          if ({wrap_o, sum_o} !== e) begin
            errors++;
            $display("FAIL scoreboard_data: got sum=%0d wrap=%0d, expected sum=%0d wrap=%0d",
                     sum_o, wrap_o, e[W-1:0], e[W]);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_mod(a_cur, b_cur));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int a, input int b);
    int n;
    logic got;
    set_vec(a, b);
    a_cur = a;
    b_cur = b;
    in_valid = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: in_ready=0 for %0d cycles, expected accept", n);
    end
  endtask

  // k = edges after the accept edge until out_valid; latency in cycles = k + 1.
  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_out_timeout: out_valid=0 after %0d cycles, expected 1", k);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_vec(0, 0);
    idle(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum_o !== '0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", sum_o); end
    checks++; if (wrap_o !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap_o); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    idle(2);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_latency();
    int k;
    idle(4);
    drive(69, 45);
    wait_out(k);
    checks++; if (k + 1 !== LAT) begin errors++; $display("FAIL latency: got %0d cycles expected %0d", k + 1, LAT); end
    checks++; if (sum_o !== 7'd6 || wrap_o !== 1'b1) begin
      errors++; $display("FAIL latency_value: got sum=%0d wrap=%0d expected sum=6 wrap=1", sum_o, wrap_o);
    end
    wait_drain();
  endtask

  task automatic test_vectors();
    int ta[4] = '{10, 107, 107, 107};
    int tb[4] = '{20, 0, 1, 107};
    int ts[4] = '{30, 107, 0, 106};
    int tw[4] = '{0, 0, 1, 1};
    int k;
    for (int i = 0; i < 4; i++) begin
      idle(2);
      drive(ta[i], tb[i]);
      wait_out(k);
      checks++; if (int'(sum_o) !== ts[i] || int'(wrap_o) !== tw[i]) begin
        errors++;
        $display("FAIL vector_%0d_plus_%0d: got sum=%0d wrap=%0d expected sum=%0d wrap=%0d",
                 ta[i], tb[i], sum_o, wrap_o, ts[i], tw[i]);
      end
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int base;
    idle(4);
    base = n_out;
    out_ready = 1'b1;
    fork
      begin
        drive(69, 45);
        drive(10, 20);
        drive(107, 1);
      end
      begin
        int k;
        wait_out(k);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          #2;
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
          checks++; if (out_valid !== 1'b1 || sum_o !== 7'd6 || wrap_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b sum=%0d wrap=%0d expected valid=1 sum=6 wrap=1",
                     out_valid, sum_o, wrap_o);
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++; if (n_out - base !== 3) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 3", n_out - base); end
  endtask

  task automatic test_reset_mid();
    int k, stale;
    idle(4);
    out_ready = 1'b1;
    drive(69, 45);
    drive(10, 20);
    drive(107, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum_o !== '0 || wrap_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_data: got sum=%0d wrap=%0d expected 0 0", sum_o, wrap_o);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready); end
    idle(2);
    rst = 1'b0;
    stale = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL stale_beat: got %0d valid cycles expected 0", stale); end
    drive(10, 20);
    wait_out(k);
    checks++; if (k + 1 !== LAT) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", k + 1, LAT); end
    checks++; if (sum_o !== 7'd30 || wrap_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_value: got sum=%0d wrap=%0d expected sum=30 wrap=0", sum_o, wrap_o);
    end
    wait_drain();
  endtask

  task automatic test_random();
    int base;
    idle(2);
    base = n_out;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          drive($urandom_range(0, M - 1), $urandom_range(0, M - 1));
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL random_drain: got %0d pending expected 0", exp_q.size()); end
    checks++; if (n_out - base !== 1000) begin errors++; $display("FAIL random_count: got %0d outputs expected 1000", n_out - base); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
